trap_sequencer: RTL and testbench
=================================

// Module: trap_sequencer
// PURPOSE
//  Consumer of the F/E exception codes produced by the exception signals handler.
//  Arbitrates F- vs E-stage exceptions and mret, then runs a fixed multi-cycle trap entry/return sequence:
//    flush, CSR update (mepc/mcause/mtval/mstatus), PC redirect, 1-cycle exception blanking.
//  Owns the hart privilege register and feeds it back to the handler and CSR file.
// PARAMETERS
//  XLEN       `XLEN_64b  2-bit width code; W = 1<<(XLEN+4) data/address bits
//  RESET_PRIV `MACHINE   privilege level loaded on reset
// PORTS
//  i_clk                     in   1  clock, rising edge
//  i_rst_n                   in   1  asynchronous active-low reset
//  i_exception_code_f        in   4  F-stage code (`NO_E = none)
//  i_pc_f                    in   W  PC of F-stage instruction
//  i_kill_f                  in   1  F instruction squashed by older redirect; F code ignored
//  i_exception_code_e        in   4  E-stage code
//  i_pc_e                    in   W  PC of E-stage instruction
//  i_alu_out_e               in   W  E-stage effective address
//  i_mret_e                  in   1  mret in E stage
//  i_mtvec                   in   W  trap vector CSR (direct mode only)
//  i_mepc                    in   W  current mepc CSR
//  i_mstatus_mie/_mpie       in   1  current mstatus bits
//  i_mstatus_mpp             in   2  current mstatus.MPP
//  o_flush                   out  1  flush all pipeline stages
//  o_stall                   out  1  freeze PC/pipeline registers
//  o_csr_we                  out  1  strobe: write o_mepc/o_mcause/o_mtval/o_mstatus_*
//  o_mepc, o_mcause, o_mtval out  W  values for trap-CSR write
//  o_mstatus_mie/_mpie       out  1  next mstatus bits
//  o_mstatus_mpp             out  2  next mstatus.MPP
//  o_redirect_valid          out  1  1-cycle strobe: load o_redirect_pc into PC
//  o_redirect_pc             out  W  trap target or return target
//  o_disable_exceptions_1cc  out  1  blanks the exception handler for one cycle
//  o_current_privilege       out  2  hart privilege (`USER/`SUPERVISOR/`MACHINE)
//  o_busy                    out  1  state != IDLE
// BEHAVIOUR
//  Reset (async): state IDLE, all outputs 0 except o_current_privilege = RESET_PRIV.
//    Reset mid-sequence abandons it; no CSR write or redirect completes.
//  FSM (trap entry): IDLE -> FLUSH -> CSR_WR -> REDIRECT -> BLANK -> IDLE.
//  FSM (mret):       IDLE -> FLUSH -> RET_WR -> REDIRECT -> BLANK -> IDLE.
//  Trigger sampled only in IDLE; priority:
//    1. E code != `NO_E
//    2. i_mret_e
//    3. F code != `NO_E with !i_kill_f
//    Capture code, PC, address into registers at that edge.
//  Triggers arriving while o_busy=1 are ignored; the flush discards their instructions.
//  Trigger at edge N:
//    FLUSH    cycle N+1
//    CSR_WR   cycle N+2
//    REDIRECT cycle N+3
//    BLANK    cycle N+4
//    IDLE     from N+5
//  Outputs per state:
//    o_flush=1 in FLUSH and REDIRECT.
//    o_stall=1 in FLUSH, CSR_WR/RET_WR and REDIRECT.
//    o_csr_we=1 only in CSR_WR/RET_WR.
//    o_redirect_valid=1 only in REDIRECT.
//    o_disable_exceptions_1cc=1 only in BLANK.
//  mcause mapping (zero-extended to W):
//    `E_FETCH_ADDR_MISALIGNED=0, `E_ILLEGAL_INSTR=2, `E_LOAD_ADDR_MISALIGNED=4
//    `E_LOAD_ACCESS_FAULT=5, `E_STORE_ADDR_MISALIGNED=6, `E_STORE_ACCESS_FAULT=7
//    `E_ECALL=8+captured privilege (U=8, S=9, M=11)
//  mepc = captured PC (i_pc_e for E/mret, i_pc_f for F).
//  mtval:
//    fetch misaligned -> i_pc_f
//    load/store misaligned/access -> i_alu_out_e
//    illegal/ecall -> 0
//  CSR_WR:
//    MPIE<=MIE, MIE<=0, MPP<=o_current_privilege
//    privilege<=`MACHINE at end of cycle
//  RET_WR:
//    privilege<=MPP, MIE<=MPIE, MPIE<=1, MPP<=`USER
//    mepc/mcause/mtval unchanged: o_mepc=i_mepc, o_mcause/o_mtval = current values are not driven; o_csr_we covers mstatus only
//  o_redirect_pc:
//    trap -> {i_mtvec[W-1:2],2'b00}
//    mret -> {i_mepc[W-1:2],2'b00}
//  mret with privilege != `MACHINE is taken as `E_ILLEGAL_INSTR trap (mcause 2, mtval 0).
//  E exception and i_mret_e same cycle: exception wins.
//  mret and F exception same cycle: mret wins.
//  Unknown code value: treated as `E_ILLEGAL_INSTR.
// TESTING
//  1. Reset low mid-CSR_WR -> next cycle IDLE, all outputs 0, privilege=`MACHINE, no redirect.
//  2. Priv U, i_exception_code_e=`E_LOAD_ADDR_MISALIGNED, pc_e=0x100, alu_out=0x2003, mtvec=0x80
//     -> N+2 csr_we, mcause=4, mepc=0x100, mtval=0x2003, MPP=U
//     -> N+3 redirect 0x80; N+4 blank; priv=M.
//  3. Priv U, `E_ECALL -> mcause=8; priv S -> 9.
//     Then mret in M with MPP=S, mepc=0x204 -> redirect 0x204, priv=S, MPP=U, MIE=old MPIE.
//  4. Same cycle: F `E_ILLEGAL_INSTR + E `E_STORE_ACCESS_FAULT -> mcause=7, mepc=pc_e.
//  5. F `E_FETCH_ADDR_MISALIGNED with i_kill_f=1 -> no trigger, o_busy stays 0.
//     Same with i_kill_f=0, pc_f=0x1002 -> mcause=0, mtval=0x1002.
//  6. New E exception during REDIRECT -> ignored; sequence ends IDLE at N+5; mret in U -> mcause=2.

Source files
------------

// File: rtl/trap_sequencer.sv
// Trap entry / mret return sequencer: arbitrates E/F exceptions and mret, then walks
// FLUSH -> CSR write -> REDIRECT -> BLANK, and owns the hart privilege register.
module trap_sequencer #(
    parameter logic [1:0] XLEN       = 2'd2,
    parameter logic [1:0] RESET_PRIV = 2'b11,
    localparam int        W          = 1 << (XLEN + 4)
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [3:0]   i_exception_code_f,
    input  logic [W-1:0] i_pc_f,
    input  logic         i_kill_f,
    input  logic [3:0]   i_exception_code_e,
    input  logic [W-1:0] i_pc_e,
    input  logic [W-1:0] i_alu_out_e,
    input  logic         i_mret_e,
    input  logic [W-1:0] i_mtvec,
    input  logic [W-1:0] i_mepc,
    input  logic         i_mstatus_mie,
    input  logic         i_mstatus_mpie,
    input  logic [1:0]   i_mstatus_mpp,
    output logic         o_flush,
    output logic         o_stall,
    output logic         o_csr_we,
    output logic [W-1:0] o_mepc,
    output logic [W-1:0] o_mcause,
    output logic [W-1:0] o_mtval,
    output logic         o_mstatus_mie,
    output logic         o_mstatus_mpie,
    output logic [1:0]   o_mstatus_mpp,
    output logic         o_redirect_valid,
    output logic [W-1:0] o_redirect_pc,
    output logic         o_disable_exceptions_1cc,
    output logic [1:0]   o_current_privilege,
    output logic         o_busy
);
    localparam logic [3:0] NO_E                    = 4'd0;
    localparam logic [3:0] E_FETCH_ADDR_MISALIGNED = 4'd1;
    localparam logic [3:0] E_ILLEGAL_INSTR         = 4'd2;
    localparam logic [3:0] E_LOAD_ADDR_MISALIGNED  = 4'd3;
    localparam logic [3:0] E_LOAD_ACCESS_FAULT     = 4'd4;
    localparam logic [3:0] E_STORE_ADDR_MISALIGNED = 4'd5;
    localparam logic [3:0] E_STORE_ACCESS_FAULT    = 4'd6;
    localparam logic [3:0] E_ECALL                 = 4'd7;
    localparam logic [1:0] USER                    = 2'b00;
    localparam logic [1:0] MACHINE                 = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_FLUSH, S_CSR_WR, S_RET_WR, S_REDIRECT, S_BLANK
    } state_e;

    state_e       state_q, state_d;
    logic         is_ret_q;
    logic [3:0]   cause_q;
    logic [W-1:0] mepc_q, mtval_q;
    logic [1:0]   priv_q;

    logic         take, take_ret;
    logic [3:0]   code;
    logic [3:0]   cause_d;
    logic [W-1:0] pc_d, mtval_d;

    // Trigger arbitration: E exception > mret > unkilled F exception.
    always_comb begin
        take     = 1'b0;
        take_ret = 1'b0;
        code     = E_ILLEGAL_INSTR;
        pc_d     = i_pc_e;
        if (i_exception_code_e != NO_E) begin
            take = 1'b1;
            code = i_exception_code_e;
        end else if (i_mret_e) begin
            take     = 1'b1;
            take_ret = (priv_q == MACHINE);
        end else if (i_exception_code_f != NO_E && !i_kill_f) begin
            take = 1'b1;
            code = i_exception_code_f;
            pc_d = i_pc_f;
        end
        cause_d = 4'd2;
        mtval_d = '0;
        case (code)
            E_FETCH_ADDR_MISALIGNED: begin cause_d = 4'd0; mtval_d = i_pc_f;      end
            E_LOAD_ADDR_MISALIGNED:  begin cause_d = 4'd4; mtval_d = i_alu_out_e; end
            E_LOAD_ACCESS_FAULT:     begin cause_d = 4'd5; mtval_d = i_alu_out_e; end
            E_STORE_ADDR_MISALIGNED: begin cause_d = 4'd6; mtval_d = i_alu_out_e; end
            E_STORE_ACCESS_FAULT:    begin cause_d = 4'd7; mtval_d = i_alu_out_e; end
            E_ECALL:                 cause_d = {2'b10, priv_q};
            default:                 ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= S_IDLE;
            is_ret_q <= 1'b0;
            cause_q  <= '0;
            mepc_q   <= '0;
            mtval_q  <= '0;
            priv_q   <= RESET_PRIV;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && take) begin
                is_ret_q <= take_ret;
                cause_q  <= cause_d;
                mepc_q   <= pc_d;
                mtval_q  <= mtval_d;
            end
            if (state_q == S_CSR_WR)      priv_q <= MACHINE;
            else if (state_q == S_RET_WR) priv_q <= i_mstatus_mpp;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (take) state_d = S_FLUSH;
            S_FLUSH:    state_d = is_ret_q ? S_RET_WR : S_CSR_WR;
            S_CSR_WR,
            S_RET_WR:   state_d = S_REDIRECT;
            S_REDIRECT: state_d = S_BLANK;
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        o_flush                  = 1'b0;
        o_stall                  = 1'b0;
        o_csr_we                 = 1'b0;
        o_mepc                   = '0;
        o_mcause                 = '0;
        o_mtval                  = '0;
        o_mstatus_mie            = 1'b0;
        o_mstatus_mpie           = 1'b0;
        o_mstatus_mpp            = USER;
        o_redirect_valid         = 1'b0;
        o_redirect_pc            = '0;
        o_disable_exceptions_1cc = 1'b0;
        case (state_q)
            S_FLUSH: begin
                o_flush = 1'b1;
                o_stall = 1'b1;
            end
            S_CSR_WR: begin
                o_stall        = 1'b1;
                o_csr_we       = 1'b1;
                o_mepc         = mepc_q;
                o_mcause       = {{(W-4){1'b0}}, cause_q};
                o_mtval        = mtval_q;
                o_mstatus_mie  = 1'b0;
                o_mstatus_mpie = i_mstatus_mie;
                o_mstatus_mpp  = priv_q;
            end
            S_RET_WR: begin
                o_stall        = 1'b1;
                o_csr_we       = 1'b1;
                o_mepc         = i_mepc;
                o_mstatus_mie  = i_mstatus_mpie;
                o_mstatus_mpie = 1'b1;
                o_mstatus_mpp  = USER;
            end
            S_REDIRECT: begin
                o_flush          = 1'b1;
                o_stall          = 1'b1;
                o_redirect_valid = 1'b1;
                o_redirect_pc    = is_ret_q ? {i_mepc[W-1:2], 2'b00} : {i_mtvec[W-1:2], 2'b00};
            end
            S_BLANK:  o_disable_exceptions_1cc = 1'b1;
            default:  ;
        endcase
    end

    assign o_current_privilege = priv_q;
    assign o_busy              = (state_q != S_IDLE);

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer: trap entry, mret, arbitration, kill, busy-ignore, reset.
module tb_trap_sequencer;
    localparam int W = 64;
    localparam logic [3:0] NO_E = 4'd0, FETCH_MIS = 4'd1, ILLEGAL = 4'd2, LOAD_MIS = 4'd3,
                           LOAD_AF = 4'd4, STORE_AF = 4'd6, ECALL = 4'd7;
    localparam logic [1:0] PU = 2'b00, PS = 2'b01, PM = 2'b11;

    logic         i_clk = 1'b0, i_rst_n = 1'b0;
    logic [3:0]   i_exception_code_f = NO_E, i_exception_code_e = NO_E;
    logic [W-1:0] i_pc_f = '0, i_pc_e = '0, i_alu_out_e = '0, i_mtvec = '0, i_mepc = '0;
    logic         i_kill_f = 1'b0, i_mret_e = 1'b0;
    logic         i_mstatus_mie = 1'b0, i_mstatus_mpie = 1'b0;
    logic [1:0]   i_mstatus_mpp = PU;
    logic         o_flush, o_stall, o_csr_we, o_mstatus_mie, o_mstatus_mpie;
    logic [W-1:0] o_mepc, o_mcause, o_mtval, o_redirect_pc;
    logic [1:0]   o_mstatus_mpp, o_current_privilege;
    logic         o_redirect_valid, o_disable_exceptions_1cc, o_busy;

    int checks = 0, failures = 0;

    trap_sequencer dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_exception_code_f(i_exception_code_f), .i_pc_f(i_pc_f), .i_kill_f(i_kill_f),
        .i_exception_code_e(i_exception_code_e), .i_pc_e(i_pc_e), .i_alu_out_e(i_alu_out_e),
        .i_mret_e(i_mret_e), .i_mtvec(i_mtvec), .i_mepc(i_mepc),
        .i_mstatus_mie(i_mstatus_mie), .i_mstatus_mpie(i_mstatus_mpie), .i_mstatus_mpp(i_mstatus_mpp),
        .o_flush(o_flush), .o_stall(o_stall), .o_csr_we(o_csr_we),
        .o_mepc(o_mepc), .o_mcause(o_mcause), .o_mtval(o_mtval),
        .o_mstatus_mie(o_mstatus_mie), .o_mstatus_mpie(o_mstatus_mpie), .o_mstatus_mpp(o_mstatus_mpp),
        .o_redirect_valid(o_redirect_valid), .o_redirect_pc(o_redirect_pc),
        .o_disable_exceptions_1cc(o_disable_exceptions_1cc),
        .o_current_privilege(o_current_privilege), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Presents one trigger across a single rising edge, then withdraws it.
    task automatic trig(input logic [3:0] ce, input logic mret, input logic [3:0] cf, input logic kill);
        i_exception_code_e = ce;
        i_mret_e           = mret;
        i_exception_code_f = cf;
        i_kill_f           = kill;
        step();
        i_exception_code_e = NO_E;
        i_mret_e           = 1'b0;
        i_exception_code_f = NO_E;
        i_kill_f           = 1'b0;
    endtask

    task automatic check_entry(input string tag, input logic [W-1:0] cause, input logic [W-1:0] epc,
                               input logic [W-1:0] tval, input logic [1:0] mpp,
                               input logic [W-1:0] redir, input logic inject);
        chk({tag, ".n1.flush"}, W'(o_flush), 1);
        chk({tag, ".n1.stall"}, W'(o_stall), 1);
        chk({tag, ".n1.csr_we"}, W'(o_csr_we), 0);
        step();
        chk({tag, ".n2.csr_we"}, W'(o_csr_we), 1);
        chk({tag, ".n2.flush"}, W'(o_flush), 0);
        chk({tag, ".n2.mcause"}, o_mcause, cause);
        chk({tag, ".n2.mepc"}, o_mepc, epc);
        chk({tag, ".n2.mtval"}, o_mtval, tval);
        chk({tag, ".n2.mpp"}, W'(o_mstatus_mpp), W'(mpp));
        chk({tag, ".n2.mie"}, W'(o_mstatus_mie), 0);
        chk({tag, ".n2.mpie"}, W'(o_mstatus_mpie), W'(i_mstatus_mie));
        step();
        chk({tag, ".n3.redirect_valid"}, W'(o_redirect_valid), 1);
        chk({tag, ".n3.redirect_pc"}, o_redirect_pc, redir);
        chk({tag, ".n3.csr_we"}, W'(o_csr_we), 0);
        if (inject) i_exception_code_e = LOAD_AF;
        step();
        i_exception_code_e = NO_E;
        chk({tag, ".n4.blank"}, W'(o_disable_exceptions_1cc), 1);
        chk({tag, ".n4.redirect_valid"}, W'(o_redirect_valid), 0);
        chk({tag, ".n4.priv"}, W'(o_current_privilege), W'(PM));
        step();
        chk({tag, ".n5.busy"}, W'(o_busy), 0);
        chk({tag, ".n5.blank"}, W'(o_disable_exceptions_1cc), 0);
    endtask

    // mret in M: i_mstatus_mpie=1, i_mstatus_mie=0 so MIE<=MPIE is distinguishable from a zero.
    task automatic do_mret(input string tag, input logic [1:0] mpp, input logic [W-1:0] epc,
                           input logic [3:0] cf);
        i_mstatus_mpp  = mpp;
        i_mepc         = epc;
        i_mstatus_mie  = 1'b0;
        i_mstatus_mpie = 1'b1;
        trig(NO_E, 1'b1, cf, 1'b0);
        chk({tag, ".n1.busy"}, W'(o_busy), 1);
        step();
        chk({tag, ".n2.csr_we"}, W'(o_csr_we), 1);
        chk({tag, ".n2.mepc"}, o_mepc, epc);
        chk({tag, ".n2.mie"}, W'(o_mstatus_mie), 1);
        chk({tag, ".n2.mpie"}, W'(o_mstatus_mpie), 1);
        chk({tag, ".n2.mpp"}, W'(o_mstatus_mpp), W'(PU));
        step();
        chk({tag, ".n3.redirect_valid"}, W'(o_redirect_valid), 1);
        chk({tag, ".n3.redirect_pc"}, o_redirect_pc, {epc[W-1:2], 2'b00});
        step();
        chk({tag, ".n4.priv"}, W'(o_current_privilege), W'(mpp));
        step();
        chk({tag, ".n5.busy"}, W'(o_busy), 0);
        i_mstatus_mie  = 1'b1;
        i_mstatus_mpie = 1'b0;
    endtask

    initial begin
        i_mtvec = 64'h80;
        #12;
        chk("rst.busy", W'(o_busy), 0);
        chk("rst.priv", W'(o_current_privilege), W'(PM));
        chk("rst.flush", W'(o_flush), 0);
        chk("rst.redirect", W'(o_redirect_valid), 0);
        i_rst_n = 1'b1;
        i_mstatus_mie = 1'b1;
        step();

        // Drop to U, then reset in the middle of CSR_WR.
        do_mret("ret_u0", PU, 64'h40, NO_E);
        chk("pre_rst.priv", W'(o_current_privilege), W'(PU));
        i_pc_e = 64'h111;
        trig(ILLEGAL, 1'b0, NO_E, 1'b0);
        step();
        chk("midrst.csr_we_before", W'(o_csr_we), 1);
        i_rst_n = 1'b0;
        #1;
        chk("midrst.busy", W'(o_busy), 0);
        chk("midrst.csr_we", W'(o_csr_we), 0);
        chk("midrst.stall", W'(o_stall), 0);
        chk("midrst.mcause", o_mcause, 0);
        chk("midrst.priv", W'(o_current_privilege), W'(PM));
        #2 i_rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("postrst.redirect", W'(o_redirect_valid), 0);
            chk("postrst.busy", W'(o_busy), 0);
        end

        // Load misaligned from U.
        do_mret("ret_u1", PU, 64'h44, NO_E);
        i_pc_e = 64'h100; i_alu_out_e = 64'h2003;
        trig(LOAD_MIS, 1'b0, NO_E, 1'b0);
        check_entry("ldmis", 4, 64'h100, 64'h2003, PU, 64'h80, 1'b0);

        // ecall from U and from S; mtvec low bits are masked off the target.
        i_mtvec = 64'h83;
        do_mret("ret_u2", PU, 64'h48, NO_E);
        i_pc_e = 64'h150;
        trig(ECALL, 1'b0, NO_E, 1'b0);
        check_entry("ecall_u", 8, 64'h150, 0, PU, 64'h80, 1'b0);
        do_mret("ret_s", PS, 64'h4c, ILLEGAL);
        chk("ret_s.priv", W'(o_current_privilege), W'(PS));
        i_pc_e = 64'h160;
        trig(ECALL, 1'b0, NO_E, 1'b0);
        check_entry("ecall_s", 9, 64'h160, 0, PS, 64'h80, 1'b0);
        do_mret("ret_204", PS, 64'h204, NO_E);

        // E store access fault beats F illegal in the same cycle.
        i_pc_e = 64'h300; i_alu_out_e = 64'h404; i_pc_f = 64'h308;
        trig(STORE_AF, 1'b0, ILLEGAL, 1'b0);
        check_entry("e_over_f", 7, 64'h300, 64'h404, PS, 64'h80, 1'b0);

        // Killed F exception never triggers; unkilled one does.
        i_pc_f = 64'h1002;
        i_exception_code_f = FETCH_MIS; i_kill_f = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("kill.busy", W'(o_busy), 0);
        end
        trig(NO_E, 1'b0, FETCH_MIS, 1'b0);
        check_entry("fetchmis", 0, 64'h1002, 64'h1002, PM, 64'h80, 1'b0);

        // A new E exception during REDIRECT is ignored.
        i_pc_e = 64'h500;
        trig(ILLEGAL, 1'b0, NO_E, 1'b0);
        check_entry("busy_ign", 2, 64'h500, 0, PM, 64'h80, 1'b1);
        step();
        chk("busy_ign.n6.busy", W'(o_busy), 0);

        // mret outside M becomes an illegal-instruction trap.
        do_mret("ret_u3", PU, 64'h50, NO_E);
        i_pc_e = 64'h600;
        trig(NO_E, 1'b1, NO_E, 1'b0);
        check_entry("mret_u", 2, 64'h600, 0, PU, 64'h80, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
